// File: rtl/writeback_buffer_pkg.sv
// rtl/writeback_buffer_pkg.sv - shared types and forwarding search helper for the writeback buffer
package writeback_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } fwd_t;

    // Fold one candidate into the running search; callers visit candidates oldest first,
    // so the last match seen (the youngest) wins.
    function automatic fwd_t fwd_step(input fwd_t acc, input logic valid,
                                      input wb_entry_t e, input logic [ADDR_W-1:0] idx);
        fwd_t r;
        r = acc;
        if (valid && (e.dst == idx)) begin
            r.hit  = 1'b1;
            r.data = e.data;
        end
        return r;
    endfunction

endpackage

// File: rtl/writeback_buffer_if.sv
// rtl/writeback_buffer_if.sv - producer, register file write and forwarding signals of the writeback buffer
interface writeback_buffer_if #(
    parameter int DEPTH = 4
);
    import writeback_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_a_reg;
    logic [ADDR_W-1:0] rd_b_reg;
    logic              fwd_a_hit;
    logic [DATA_W-1:0] fwd_a_data;
    logic              fwd_b_hit;
    logic [DATA_W-1:0] fwd_b_data;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rd_a_reg, rd_b_reg,
        output in_ready, wr_en, wr_reg, wr_data, fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data,
               count, overflow
    );

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rd_a_reg, rd_b_reg,
        input  in_ready, wr_en, wr_reg, wr_data, fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data,
               count, overflow
    );

endinterface

// File: rtl/wb_dual_push_fifo.sv
// rtl/wb_dual_push_fifo.sv - queue of writeback entries with two ordered pushes and one pop per cycle
module wb_dual_push_fifo
    import writeback_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push0_valid,
    input  wb_entry_t        push0_entry,
    input  logic             push1_valid,
    input  wb_entry_t        push1_entry,
    input  logic             pop,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid_mask,
    output logic [PTR_W-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_p1;
    logic             pop_eff;
    logic [1:0]       n_push;
    wb_entry_t        mem [DEPTH];

    assign pop_eff = pop && (count != '0);
    assign n_push  = {1'b0, push0_valid} + {1'b0, push1_valid};
    assign tail_p1 = tail + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop_eff) begin
                head <= head + PTR_W'(1);
            end
            tail  <= tail + PTR_W'(n_push);
            count <= count + CNT_W'(n_push) - CNT_W'(pop_eff);
        end
    end

    // push0 always lands first so it is the older of a same-cycle pair
    always_ff @(posedge clk) begin
        if (push0_valid) begin
            mem[tail] <= push0_entry;
            if (push1_valid) begin
                mem[tail_p1] <= push1_entry;
            end
        end else if (push1_valid) begin
            mem[tail] <= push1_entry;
        end
    end

    always_comb begin
        logic [PTR_W-1:0] off;
        off        = '0;
        valid_mask = '0;
        for (int s = 0; s < DEPTH; s++) begin
            off           = PTR_W'(s) - head;
            valid_mask[s] = CNT_W'(off) < count;
        end
    end

    assign entries = mem;

endmodule

// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - queues ALU and load results, writes the register file and forwards pending values
module writeback_buffer
    import writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    writeback_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  valid_mask;
    logic [PTR_W-1:0]  head;
    logic [CNT_W-1:0]  count;
    logic              in_ready;
    logic              pop;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic              overflow;
    fwd_t              fa;
    fwd_t              fb;

    // Two free slots are required so a dual push never depends on the same-cycle pop
    assign in_ready = count <= CNT_W'(DEPTH - 2);
    assign pop      = count != '0;

    wb_dual_push_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0_valid (bus.mem_valid & in_ready),
        .push0_entry ('{dst: bus.mem_reg, data: bus.mem_data}),
        .push1_valid (bus.alu_valid & in_ready),
        .push1_entry ('{dst: bus.alu_reg, data: bus.alu_data}),
        .pop         (pop),
        .entries     (entries),
        .valid_mask  (valid_mask),
        .head        (head),
        .count       (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_reg   <= '0;
            wr_data  <= '0;
            overflow <= 1'b0;
        end else begin
            wr_en <= pop;
            if (pop) begin
                wr_reg  <= entries[head].dst;
                wr_data <= entries[head].data;
            end
            if (!in_ready && (bus.alu_valid || bus.mem_valid)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output stage is visited first so any queued match overrides it
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot = '0;
        fa   = '0;
        fb   = '0;
        fa   = fwd_step(fa, wr_en, '{dst: wr_reg, data: wr_data}, bus.rd_a_reg);
        fb   = fwd_step(fb, wr_en, '{dst: wr_reg, data: wr_data}, bus.rd_b_reg);
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PTR_W'(i);
            fa   = fwd_step(fa, valid_mask[slot], entries[slot], bus.rd_a_reg);
            fb   = fwd_step(fb, valid_mask[slot], entries[slot], bus.rd_b_reg);
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en;
    assign bus.wr_reg     = wr_reg;
    assign bus.wr_data    = wr_data;
    assign bus.fwd_a_hit  = fa.hit;
    assign bus.fwd_a_data = fa.data;
    assign bus.fwd_b_hit  = fb.hit;
    assign bus.fwd_b_data = fb.data;
    assign bus.count      = count;
    assign bus.overflow   = overflow;

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - directed self-checking bench for writeback_buffer
module tb_writeback_buffer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    writeback_buffer_if #(.DEPTH(4)) bus ();

    writeback_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                         input logic av, input logic [3:0] ar, input logic [15:0] ad);
        bus.mem_valid = mv;
        bus.mem_reg   = mr;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [3:0] r,
                          input logic [15:0] d, input logic [2:0] cnt);
        chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(en));
        chk({tag, ".wr_reg"}, 32'(bus.wr_reg), 32'(r));
        chk({tag, ".wr_data"}, 32'(bus.wr_data), 32'(d));
        chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
    endtask

    task automatic chk_fa(input string tag, input logic hit, input logic [15:0] d);
        chk({tag, ".fwd_a_hit"}, 32'(bus.fwd_a_hit), 32'(hit));
        chk({tag, ".fwd_a_data"}, 32'(bus.fwd_a_data), 32'(d));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bus.rd_a_reg = 4'd0;
        bus.rd_b_reg = 4'd0;

        // 1: asynchronous reset with random inputs, checked before any clock edge
        #1;
        rst_n = 1'b0;
        drive(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), 16'($urandom));
        bus.rd_a_reg = 4'($urandom);
        bus.rd_b_reg = 4'($urandom);
        #1;
        chk_wr("rst", 0, 0, 16'h0000, 0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.overflow", 32'(bus.overflow), 32'd0);
        chk("rst.fwd_a_hit", 32'(bus.fwd_a_hit), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // 2: single alu push
        drive(0, 0, 0, 1, 4'd3, 16'h1234);
        bus.rd_a_reg = 4'd3;
        bus.rd_b_reg = 4'd7;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_wr("t2.e1", 0, 0, 16'h0000, 1);
        chk_fa("t2.e1", 1, 16'h1234);
        chk("t2.e1.fwd_b_hit", 32'(bus.fwd_b_hit), 32'd0);
        chk("t2.e1.fwd_b_data", 32'(bus.fwd_b_data), 32'd0);
        tick();
        chk_wr("t2.e2", 1, 4'd3, 16'h1234, 0);
        chk_fa("t2.e2", 1, 16'h1234);
        tick();
        chk_wr("t2.e3", 0, 4'd3, 16'h1234, 0);
        chk_fa("t2.e3", 0, 16'h0000);

        // 3: same destination from both producers, alu is younger
        drive(1, 4'd5, 16'hAAAA, 1, 4'd5, 16'h5555);
        bus.rd_a_reg = 4'd5;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_wr("t3.e1", 0, 4'd3, 16'h1234, 2);
        chk_fa("t3.e1", 1, 16'h5555);
        tick();
        chk_wr("t3.e2", 1, 4'd5, 16'hAAAA, 1);
        chk_fa("t3.e2", 1, 16'h5555);
        tick();
        chk_wr("t3.e3", 1, 4'd5, 16'h5555, 0);
        chk_fa("t3.e3", 1, 16'h5555);
        tick();
        chk_wr("t3.e4", 0, 4'd5, 16'h5555, 0);

        // 4: dual pushes every edge until in_ready drops, then a forced dropped push
        bus.rd_b_reg = 4'd7;
        drive(1, 4'd1, 16'h0101, 1, 4'd2, 16'h0202);
        tick();
        chk_wr("t4.e1", 0, 4'd5, 16'h5555, 2);
        chk("t4.e1.in_ready", 32'(bus.in_ready), 32'd1);
        drive(1, 4'd3, 16'h0303, 1, 4'd4, 16'h0404);
        tick();
        chk_wr("t4.e2", 1, 4'd1, 16'h0101, 3);
        chk("t4.e2.in_ready", 32'(bus.in_ready), 32'd0);
        chk("t4.e2.overflow", 32'(bus.overflow), 32'd0);
        drive(1, 4'd6, 16'hDEAD, 1, 4'd7, 16'hBEEF);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_wr("t4.e3", 1, 4'd2, 16'h0202, 2);
        chk("t4.e3.overflow", 32'(bus.overflow), 32'd1);
        chk("t4.e3.fwd_b_hit", 32'(bus.fwd_b_hit), 32'd0);
        tick();
        chk_wr("t4.e4", 1, 4'd3, 16'h0303, 1);
        tick();
        chk_wr("t4.e5", 1, 4'd4, 16'h0404, 0);
        chk("t4.e5.fwd_b_hit", 32'(bus.fwd_b_hit), 32'd0);
        tick();
        chk_wr("t4.e6", 0, 4'd4, 16'h0404, 0);

        // 5: fill to three entries, then drain with no pushes
        bus.rd_a_reg = 4'd11;
        drive(1, 4'd8, 16'h0808, 1, 4'd9, 16'h0909);
        tick();
        chk_wr("t5.f1", 0, 4'd4, 16'h0404, 2);
        drive(1, 4'd10, 16'h0A0A, 1, 4'd11, 16'h0B0B);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_wr("t5.f2", 1, 4'd8, 16'h0808, 3);
        chk_fa("t5.f2", 1, 16'h0B0B);
        tick();
        chk_wr("t5.d1", 1, 4'd9, 16'h0909, 2);
        tick();
        chk_wr("t5.d2", 1, 4'd10, 16'h0A0A, 1);
        tick();
        chk_wr("t5.d3", 1, 4'd11, 16'h0B0B, 0);
        chk_fa("t5.d3", 1, 16'h0B0B);
        tick();
        chk_wr("t5.d4", 0, 4'd11, 16'h0B0B, 0);
        chk_fa("t5.d4", 0, 16'h0000);
        chk("t5.overflow", 32'(bus.overflow), 32'd1);

        // 6: reset pulsed mid-drain with three entries queued
        drive(1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222);
        tick();
        drive(1, 4'd3, 16'h3333, 1, 4'd4, 16'h4444);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        bus.rd_a_reg = 4'd4;
        #1;
        chk_wr("t6.pre", 1, 4'd1, 16'h1111, 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk_wr("t6.rst", 0, 0, 16'h0000, 0);
        chk("t6.rst.overflow", 32'(bus.overflow), 32'd0);
        chk("t6.rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk_fa("t6.rst", 0, 16'h0000);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk_wr("t6.idle1", 0, 0, 16'h0000, 0);
        tick();
        chk_wr("t6.idle2", 0, 0, 16'h0000, 0);
        drive(0, 0, 0, 1, 4'd6, 16'h6666);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_wr("t6.p1", 0, 0, 16'h0000, 1);
        tick();
        chk_wr("t6.p2", 1, 4'd6, 16'h6666, 0);
        tick();
        chk_wr("t6.p3", 0, 4'd6, 16'h6666, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
